wave_rom_scheduler: RTL

//   Sequences and shares the single-port waveform ROM (TABLE_LEN 8-bit samples) between two requesters:
//   DAC playback (periodic sample strobe, high priority) and the digitron display sampler (low priority).

---
 rtl/wave_pkg.sv | 35 +++
 rtl/wave_rom_scheduler_key_edge_cfg.sv | 50 +++++
 rtl/wave_rom_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// Shared constants, key bit indices and arbiter state type for the waveform ROM scheduler.
package wave_pkg;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 8;
  localparam int TABLE_LEN = 2000;
  localparam int ROM_LAT   = 2;
  localparam int STEP_RST  = 2;
  localparam int STEP_MAX  = 64;

  localparam int KEY_STEP_UP = 0;
  localparam int KEY_STEP_DN = 1;
  localparam int KEY_RUN     = 2;
  localparam int KEY_RESTART = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DAC_RD,
    ST_DISP_RD
  } arb_state_e;

  // Widened by one bit so phase+step can never wrap before the table-length compare.
  function automatic logic [ADDR_W-1:0] next_phase(input logic [ADDR_W-1:0] phase,
                                                   input logic [7:0]        step);
    logic [ADDR_W:0] limit;
    logic [ADDR_W:0] sum;
    limit = (ADDR_W+1)'(TABLE_LEN) - (ADDR_W+1)'(step);
    sum   = {1'b0, phase} + (ADDR_W+1)'(step);
    if ({1'b0, phase} >= limit) begin
      return '0;
    end
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/wave_rom_scheduler_key_edge_cfg.sv
// Key rising-edge detection plus the step-size and run/pause configuration registers.
module key_edge_cfg
  import wave_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key_state,
  output logic [7:0] step_out,
  output logic       running,
  output logic       restart
);

  logic [3:0] key_prev_q, key_prev_d;
  logic [3:0] rise;
  logic [7:0] step_q, step_d;
  logic       running_q, running_d;
  logic       unused_keys;

  assign unused_keys = ^key_state[9:4];

  // Opposing step keys on the same edge cancel out.
  always_comb begin
    key_prev_d = key_state[3:0];
    rise       = key_state[3:0] & ~key_prev_q;
    step_d     = step_q;
    running_d  = running_q ^ rise[KEY_RUN];
    if (rise[KEY_STEP_UP] && !rise[KEY_STEP_DN] && (step_q < 8'(STEP_MAX))) begin
      step_d = step_q + 8'd1;
    end else if (rise[KEY_STEP_DN] && !rise[KEY_STEP_UP] && (step_q > 8'd1)) begin
      step_d = step_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_q <= '0;
      step_q     <= 8'(STEP_RST);
      running_q  <= 1'b1;
    end else begin
      key_prev_q <= key_prev_d;
      step_q     <= step_d;
      running_q  <= running_d;
    end
  end

  assign step_out = step_q;
  assign running  = running_q;
  assign restart  = rise[KEY_RESTART];

endmodule

// File: rtl/wave_rom_scheduler.sv
// Shares the single-port waveform ROM between DAC playback (high priority) and the display sampler.
// Holds the playback phase pointer; key configuration is delegated to key_edge_cfg.
module wave_rom_scheduler
  import wave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        key_state,
  input  logic              dac_tick,
  input  logic              disp_req,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] dac_value,
  output logic              dac_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_ack,
  output logic [7:0]        step_out,
  output logic              running,
  output logic              dac_overrun
);

  arb_state_e        state_q, state_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] phase_q, phase_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              pend_dac_q, pend_dac_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] dac_value_q, dac_value_d;
  logic              dac_valid_q, dac_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_ack_q, disp_ack_d;

  logic [7:0] step;
  logic       restart;
  logic       tick_acc;
  logic       dac_grant;

  key_edge_cfg u_key_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_state (key_state),
    .step_out  (step),
    .running   (running),
    .restart   (restart)
  );

  // A fresh tick is granted straight from IDLE, so pend_dac only holds ticks that had to wait.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    phase_d     = phase_q;
    rom_addr_d  = rom_addr_q;
    last_addr_d = last_addr_q;
    pend_dac_d  = pend_dac_q;
    overrun_d   = overrun_q;
    dac_value_d = dac_value_q;
    dac_valid_d = 1'b0;
    disp_data_d = disp_data_q;
    disp_ack_d  = 1'b0;

    tick_acc  = dac_tick & running;
    dac_grant = (state_q == ST_IDLE) && (pend_dac_q || tick_acc);

    case (state_q)
      ST_IDLE: begin
        if (dac_grant) begin
          state_d     = ST_DAC_RD;
          rom_addr_d  = phase_q;
          last_addr_d = phase_q;
          phase_d     = next_phase(phase_q, step);
          wait_cnt_d  = '0;
        end else if (disp_req) begin
          state_d    = ST_DISP_RD;
          rom_addr_d = last_addr_q;
          wait_cnt_d = '0;
        end
      end
      ST_DAC_RD, ST_DISP_RD: begin
        wait_cnt_d = wait_cnt_q + 2'd1;
        if (wait_cnt_q == 2'(ROM_LAT - 1)) begin
          state_d = ST_IDLE;
          if (state_q == ST_DAC_RD) begin
            dac_value_d = rom_q;
            dac_valid_d = 1'b1;
          end else begin
            disp_data_d = rom_q;
            disp_ack_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (dac_grant) begin
      pend_dac_d = pend_dac_q & tick_acc;
    end else if (tick_acc) begin
      overrun_d  = overrun_q | pend_dac_q;
      pend_dac_d = 1'b1;
    end

    // Phase restart wins over any advance or pending tick in the same cycle.
    if (restart) begin
      phase_d    = '0;
      pend_dac_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      phase_q     <= '0;
      rom_addr_q  <= '0;
      last_addr_q <= '0;
      pend_dac_q  <= 1'b0;
      overrun_q   <= 1'b0;
      dac_value_q <= '0;
      dac_valid_q <= 1'b0;
      disp_data_q <= '0;
      disp_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      phase_q     <= phase_d;
      rom_addr_q  <= rom_addr_d;
      last_addr_q <= last_addr_d;
      pend_dac_q  <= pend_dac_d;
      overrun_q   <= overrun_d;
      dac_value_q <= dac_value_d;
      dac_valid_q <= dac_valid_d;
      disp_data_q <= disp_data_d;
      disp_ack_q  <= disp_ack_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign dac_value   = dac_value_q;
  assign dac_valid   = dac_valid_q;
  assign disp_data   = disp_data_q;
  assign disp_ack    = disp_ack_q;
  assign step_out    = step;
  assign dac_overrun = overrun_q;

endmodule
